// File: rtl/reg_bank_32.sv
// 32-entry register bank with one write port, two registered read ports and a flat
// view of every entry for the downstream 32:1 select mux tree.
module reg_bank_32 #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re1,
    input  logic [4:0]            raddr1,
    input  logic                  re2,
    input  logic [4:0]            raddr2,
    output logic [WIDTH-1:0]      rdata1,
    output logic                  rvalid1,
    output logic [WIDTH-1:0]      rdata2,
    output logic                  rvalid2,
    output logic [32*WIDTH-1:0]   regs_flat,
    output logic [15:0]           wr_count
);

    logic [WIDTH-1:0] mem [32];
    logic             wr_ok;
    logic [WIDTH-1:0] rd1_next;
    logic [WIDTH-1:0] rd2_next;

    // A write to entry 0 is discarded entirely when it is hardwired to zero.
    always_comb begin
        wr_ok = we && !((ZERO_REG != 0) && (waddr == 5'd0));
    end

    // Zero-register forcing is applied last so it also wins over the bypass path.
    always_comb begin
        rd1_next = mem[raddr1];
        if ((BYPASS != 0) && wr_ok && (raddr1 == waddr)) begin
            rd1_next = wdata;
        end
        if ((ZERO_REG != 0) && (raddr1 == 5'd0)) begin
            rd1_next = '0;
        end
    end

    always_comb begin
        rd2_next = mem[raddr2];
        if ((BYPASS != 0) && wr_ok && (raddr2 == waddr)) begin
            rd2_next = wdata;
        end
        if ((ZERO_REG != 0) && (raddr2 == 5'd0)) begin
            rd2_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
            rdata1   <= '0;
            rvalid1  <= 1'b0;
            rdata2   <= '0;
            rvalid2  <= 1'b0;
            wr_count <= 16'd0;
        end else begin
            if (wr_ok) begin
                mem[waddr] <= wdata;
                wr_count   <= wr_count + 16'd1;
            end
            rvalid1 <= re1;
            if (re1) begin
                rdata1 <= rd1_next;
            end
            rvalid2 <= re2;
            if (re2) begin
                rdata2 <= rd2_next;
            end
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_reg_bank_32.sv
// Randomized and directed bench for reg_bank_32, checking a default instance and a
// ZERO_REG=0/BYPASS=0 instance against an array-based behavioural model.
module tb_reg_bank_32;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          re1;
    logic [4:0]    raddr1;
    logic          re2;
    logic [4:0]    raddr2;

    logic [31:0]   rdata1A, rdata2A, rdata1B, rdata2B;
    logic          rvalid1A, rvalid2A, rvalid1B, rvalid2B;
    logic [1023:0] flatA, flatB;
    logic [15:0]   countA, countB;

    int errors;
    int checks;
    bit fullCheck;

    logic [31:0] modelMem [2][32];
    logic [31:0] modelRd1 [2];
    logic [31:0] modelRd2 [2];
    logic        modelRv1 [2];
    logic        modelRv2 [2];
    logic [15:0] modelCnt [2];

    reg_bank_32 dutA (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rdata1A), .rvalid1(rvalid1A), .rdata2(rdata2A), .rvalid2(rvalid2A),
        .regs_flat(flatA), .wr_count(countA)
    );

    reg_bank_32 #(.WIDTH(32), .ZERO_REG(0), .BYPASS(0)) dutB (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rdata1B), .rvalid1(rvalid1B), .rdata2(rdata2B), .rvalid2(rvalid2B),
        .regs_flat(flatB), .wr_count(countB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instance 0 hardwires entry 0 and forwards writes; instance 1 does neither.
    function automatic logic [31:0] modelRead(input int k, input logic [4:0] a, input bit wrote);
        if (k == 0 && a == 5'd0) return 32'd0;
        if (k == 0 && wrote && a == waddr) return wdata;
        return modelMem[k][a];
    endfunction

    task automatic modelStep();
        bit wrote;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int i = 0; i < 32; i++) modelMem[k][i] = 32'd0;
                modelRd1[k] = 32'd0;
                modelRd2[k] = 32'd0;
                modelRv1[k] = 1'b0;
                modelRv2[k] = 1'b0;
                modelCnt[k] = 16'd0;
            end else begin
                wrote = we && !(k == 0 && waddr == 5'd0);
                modelRv1[k] = re1;
                modelRv2[k] = re2;
                if (re1) modelRd1[k] = modelRead(k, raddr1, wrote);
                if (re2) modelRd2[k] = modelRead(k, raddr2, wrote);
                if (wrote) begin
                    modelMem[k][waddr] = wdata;
                    modelCnt[k] = modelCnt[k] + 16'd1;
                end
            end
        end
    endtask

    task automatic compareDut(input int k, input logic [31:0] rd1, input logic rv1,
                              input logic [31:0] rd2, input logic rv2,
                              input logic [15:0] cnt, input logic [1023:0] flat);
        string p;
        p = (k == 0) ? "A" : "B";
        checkOutput({p, "_rdata1"}, rd1, modelRd1[k]);
        checkOutput({p, "_rvalid1"}, {31'd0, rv1}, {31'd0, modelRv1[k]});
        checkOutput({p, "_rdata2"}, rd2, modelRd2[k]);
        checkOutput({p, "_rvalid2"}, {31'd0, rv2}, {31'd0, modelRv2[k]});
        checkOutput({p, "_wr_count"}, {16'd0, cnt}, {16'd0, modelCnt[k]});
        if (fullCheck) begin
            for (int i = 0; i < 32; i++) begin
                checkOutput($sformatf("%s_entry%0d", p, i), flat[i*32 +: 32], modelMem[k][i]);
            end
        end
    endtask

    // Drive one cycle of inputs, clock it through the model and compare both instances.
    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                                 input logic e2, input logic [4:0] a2);
        rst_n = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        @(posedge clk);
        modelStep();
        #1;
        compareDut(0, rdata1A, rvalid1A, rdata2A, rvalid2A, countA, flatA);
        compareDut(1, rdata1B, rvalid1B, rdata2B, rvalid2B, countB, flatB);
    endtask

    function automatic logic [4:0] randAddr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        logic [31:0] heldRd2;
        errors = 0;
        checks = 0;
        fullCheck = 1'b1;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

        applyStimulus(1'b0, 1'b1, 5'd4, 32'hAAAA5555, 1'b1, 5'd4, 1'b1, 5'd4);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("reset_count", {16'd0, countA}, 32'd0);
        checkOutput("reset_entry4", flatA[4*32 +: 32], 32'd0);

        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        checkOutput("wr_rdata1", rdata1A, 32'hDEADBEEF);
        checkOutput("wr_rvalid1", {31'd0, rvalid1A}, 32'd1);
        checkOutput("wr_flat5", flatA[5*32 +: 32], 32'hDEADBEEF);

        applyStimulus(1'b1, 1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0, 1'b1, 5'd7);
        checkOutput("bypass_on", rdata2A, 32'h00001234);
        checkOutput("bypass_off", rdata2B, 32'd0);

        applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        checkOutput("zero_rdata1", rdata1A, 32'd0);
        checkOutput("zero_rdata2", rdata2A, 32'd0);
        checkOutput("zero_count", {16'd0, countA}, 32'd2);
        checkOutput("nozero_count", {16'd0, countB}, 32'd3);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        checkOutput("nozero_rd0", rdata1B, 32'hFFFFFFFF);

        heldRd2 = modelRd2[0];
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0BADF00D, 1'b1, 5'd3, 1'b0, 5'd9);
        checkOutput("idle_rvalid2", {31'd0, rvalid2A}, 32'd0);
        checkOutput("idle_rdata2", rdata2A, heldRd2);
        checkOutput("idle_rvalid1", {31'd0, rvalid1A}, 32'd1);

        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom), randAddr(), $urandom,
                          1'($urandom), randAddr(), 1'($urandom), randAddr());
        end

        applyStimulus(1'b0, 1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 1'b1, 5'd9);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
            checkOutput($sformatf("rst_rd1_%0d", i), rdata1A, 32'd0);
            checkOutput($sformatf("rst_rd2_%0d", i), rdata2B, 32'd0);
        end
        checkOutput("rst_flatA", {31'd0, |flatA}, 32'd0);
        checkOutput("rst_count", {16'd0, countA}, 32'd0);

        fullCheck = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
        end
        fullCheck = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd0);
        checkOutput("wrap_countA", {16'd0, countA}, 32'd0);
        checkOutput("wrap_countB", {16'd0, countB}, 32'd0);
        checkOutput("wrap_flat1", flatA[1*32 +: 32], 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
